// File: rtl/prog_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_timer_if
// Description : Control/status bundle for prog_timer. The master drives the
//               start/stop/mode/load controls and the new period value; the
//               slave (the timer) returns the programmed period, the en
//               pulse, run/done status and the pulse counter.
// Ports       : start, stop, oneshot, load, period_in  (master -> slave)
//               period_q, en, running, done, tick_cnt  (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_timer_if #(
  parameter int WIDTH  = 26,
  parameter int TICK_W = 8
);
  logic              start;
  logic              stop;
  logic              oneshot;
  logic              load;
  logic [WIDTH-1:0]  period_in;
  logic [WIDTH-1:0]  period_q;
  logic              en;
  logic              running;
  logic              done;
  logic [TICK_W-1:0] tick_cnt;

  modport master (
    output start, stop, oneshot, load, period_in,
    input  period_q, en, running, done, tick_cnt
  );

  modport slave (
    input  start, stop, oneshot, load, period_in,
    output period_q, en, running, done, tick_cnt
  );
endinterface
`default_nettype wire

// File: rtl/prog_timer.sv
`default_nettype none
// ============================================================================
// Module      : prog_timer
// Description : Programmable enable timer. Emits a registered one-cycle en
//               pulse every P clocks while running, with a runtime-loadable
//               period, periodic or one-shot mode, start/stop control and a
//               wrapping count of pulses since the last start.
// Ports       : clk  - clock, all logic on posedge
//               rst  - synchronous active-high reset
//               bus  - prog_timer_if.slave control/status bundle
// Revision    : 1.0 - initial release
// ============================================================================
module prog_timer #(
  parameter int          WIDTH          = 26,
  parameter int unsigned DEFAULT_PERIOD = 50_000_000,
  parameter int          TICK_W         = 8
) (
  input  wire logic      clk,
  input  wire logic      rst,
  prog_timer_if.slave    bus
);

  localparam logic [WIDTH-1:0] c_default_period = WIDTH'(DEFAULT_PERIOD);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q,   state_d;
  logic [WIDTH-1:0]  cnt_q,     cnt_d;
  logic [WIDTH-1:0]  active_q,  active_d;   // period in force for current cycle
  logic [WIDTH-1:0]  period_reg_q, period_reg_d;
  logic              oneshot_q, oneshot_d;
  logic              en_q,      en_d;
  logic              running_q, running_d;
  logic              done_q,    done_d;
  logic [TICK_W-1:0] tick_q,    tick_d;

  logic [WIDTH-1:0]  w_eff_period;
  logic              w_terminal;

  // A zero period behaves as one, so the terminal value never underflows.
  assign w_eff_period = (active_q == '0) ? WIDTH'(1) : active_q;
  assign w_terminal   = (cnt_q == (w_eff_period - WIDTH'(1)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    active_d     = active_q;
    oneshot_d    = oneshot_q;
    done_d       = done_q;
    tick_d       = tick_q;
    en_d         = 1'b0;
    period_reg_d = bus.load ? bus.period_in : period_reg_q;

    if (bus.stop) begin
      // Stop wins over start and over a coinciding terminal count.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (bus.start) begin
      // (Re)start: a load in the same cycle supplies the first period.
      state_d   = ST_RUN;
      cnt_d     = '0;
      tick_d    = '0;
      done_d    = 1'b0;
      oneshot_d = bus.oneshot;
      active_d  = bus.load ? bus.period_in : period_reg_q;
    end else if (state_q == ST_RUN) begin
      if (w_terminal) begin
        cnt_d    = '0;
        en_d     = 1'b1;
        tick_d   = tick_q + TICK_W'(1);
        // Period loads made mid-run take effect only from here.
        active_d = period_reg_q;
        if (oneshot_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end else begin
      cnt_d = '0;
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      active_q     <= c_default_period;
      period_reg_q <= c_default_period;
      oneshot_q    <= 1'b0;
      en_q         <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      tick_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      period_reg_q <= period_reg_d;
      oneshot_q    <= oneshot_d;
      en_q         <= en_d;
      running_q    <= running_d;
      done_q       <= done_d;
      tick_q       <= tick_d;
    end
  end

  assign bus.period_q = period_reg_q;
  assign bus.en       = en_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.tick_cnt = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_timer
// Description : Self-checking bench for prog_timer (DEFAULT_PERIOD=5,
//               TICK_W=3). A vector table covers reset, periodic and one-shot
//               operation; directed sequences cover mid-run load, stop vs.
//               terminal count, zero period with tick wrap, and mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_timer;

  localparam int W  = 26;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  prog_timer_if #(.WIDTH(W), .TICK_W(TW)) bus ();

  prog_timer #(.WIDTH(W), .DEFAULT_PERIOD(5), .TICK_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, start, stop, oneshot, load;
    logic [W-1:0]  pin;
    logic          en, run, done;
    logic [TW-1:0] tick;
    logic [W-1:0]  pq;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(input logic r, s, p, o, l, input int pin,
                              input logic e, ru, d, input int t, input int pq);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p; v.oneshot = o; v.load = l;
    v.pin = W'(pin); v.en = e; v.run = ru; v.done = d;
    v.tick = TW'(t); v.pq = W'(pq);
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic r, s, p, o, l, input int pin);
    rst           = r;
    bus.start     = s;
    bus.stop      = p;
    bus.oneshot   = o;
    bus.load      = l;
    bus.period_in = W'(pin);
    @(posedge clk);
    #1;
    n_vec++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.stop = 0; bus.oneshot = 0; bus.load = 0; bus.period_in = '0;

    // ---- table: reset, periodic P=5, then one-shot restart ----
    add(1,0,0,0,0,0, 0,0,0,0,5);                 // reset values
    add(0,1,0,0,0,0, 0,1,0,0,5);                 // start at c0
    for (int k = 1; k <= 16; k++) begin          // en at c5,c10,c15
      add(0,0,0,0,0,0, (k % 5 == 0), 1, 0, k / 5, 5);
    end
    add(0,1,0,1,0,0, 0,1,0,0,5);                 // one-shot restart
    for (int k = 1; k <= 4; k++) add(0,0,0,0,0,0, 0,1,0,0,5);
    add(0,0,0,0,0,0, 1,0,1,1,5);                 // single en, done, idle
    add(0,0,0,0,0,0, 0,0,1,1,5);
    add(0,0,0,0,0,0, 0,0,1,1,5);                 // idle holds done/tick

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].oneshot,
            vecs[i].load, int'(vecs[i].pin));
      chk($sformatf("v%0d.en", i),   int'(bus.en),       int'(vecs[i].en));
      chk($sformatf("v%0d.run", i),  int'(bus.running),  int'(vecs[i].run));
      chk($sformatf("v%0d.done", i), int'(bus.done),     int'(vecs[i].done));
      chk($sformatf("v%0d.tick", i), int'(bus.tick_cnt), int'(vecs[i].tick));
      chk($sformatf("v%0d.pq", i),   int'(bus.period_q), int'(vecs[i].pq));
    end

    // ---- load 3 mid-run: current period stays 5, then every 3 ----
    drive(0,1,0,0,0,0);
    chk("ld.start.run", int'(bus.running), 1);
    chk("ld.start.done", int'(bus.done), 0);
    for (int k = 1; k <= 12; k++) begin
      drive(0,0,0,0,(k == 3),3);
      chk($sformatf("ld.en@%0d", k), int'(bus.en),
          int'(k == 5 || k == 8 || k == 11));
    end
    chk("ld.tick", int'(bus.tick_cnt), 3);
    chk("ld.pq",   int'(bus.period_q), 3);

    // ---- stop+start on the terminal-count cycle ----
    drive(0,1,0,0,0,0);
    for (int k = 1; k <= 5; k++) begin
      drive(0,0,0,0,0,0);
      chk($sformatf("ss.en@%0d", k), int'(bus.en), int'(k == 3));
    end
    drive(0,1,1,0,0,0);                          // would be terminal count
    chk("ss.en",   int'(bus.en),       0);
    chk("ss.run",  int'(bus.running),  0);
    chk("ss.tick", int'(bus.tick_cnt), 1);
    chk("ss.done", int'(bus.done),     0);
    drive(0,0,0,0,0,0);
    chk("ss.idle.en",  int'(bus.en),      0);
    chk("ss.idle.run", int'(bus.running), 0);

    // ---- period 0: en every cycle, tick wraps 7->0 on 8th en ----
    drive(0,1,0,0,1,0);
    chk("z.start.en", int'(bus.en),       0);
    chk("z.pq",       int'(bus.period_q), 0);
    for (int k = 1; k <= 9; k++) begin
      drive(0,0,0,0,0,0);
      chk($sformatf("z.en@%0d", k),   int'(bus.en),       1);
      chk($sformatf("z.tick@%0d", k), int'(bus.tick_cnt), k % 8);
    end

    // ---- reset mid-run dominates a concurrent start ----
    drive(1,1,0,0,0,0);
    chk("rst.en",   int'(bus.en),       0);
    chk("rst.run",  int'(bus.running),  0);
    chk("rst.done", int'(bus.done),     0);
    chk("rst.tick", int'(bus.tick_cnt), 0);
    chk("rst.pq",   int'(bus.period_q), 5);
    drive(0,0,0,0,0,0);
    chk("post.en",  int'(bus.en),      0);
    chk("post.run", int'(bus.running), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
